// File: rtl/axi_rd_arbiter_2to1.sv
// Two-master AXI4 read arbiter: round-robin AR grant, one burst outstanding, combinational R return.
// Optional saturating grant/wait counters enabled by defining AXI_RD_ARB_PERF_EN.
module axi_rd_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s0_ar_valid,
  output logic                  s0_ar_ready,
  input  logic [ADDR_WIDTH-1:0] s0_ar_addr,
  input  logic [ID_WIDTH-1:0]   s0_ar_id,
  input  logic [7:0]            s0_ar_len,
  input  logic [2:0]            s0_ar_size,
  input  logic [1:0]            s0_ar_burst,
  output logic                  s0_r_valid,
  input  logic                  s0_r_ready,
  output logic [DATA_WIDTH-1:0] s0_r_data,
  output logic [ID_WIDTH-1:0]   s0_r_id,
  output logic [1:0]            s0_r_resp,
  output logic                  s0_r_last,
  input  logic                  s1_ar_valid,
  output logic                  s1_ar_ready,
  input  logic [ADDR_WIDTH-1:0] s1_ar_addr,
  input  logic [ID_WIDTH-1:0]   s1_ar_id,
  input  logic [7:0]            s1_ar_len,
  input  logic [2:0]            s1_ar_size,
  input  logic [1:0]            s1_ar_burst,
  output logic                  s1_r_valid,
  input  logic                  s1_r_ready,
  output logic [DATA_WIDTH-1:0] s1_r_data,
  output logic [ID_WIDTH-1:0]   s1_r_id,
  output logic [1:0]            s1_r_resp,
  output logic                  s1_r_last,
  output logic                  m_ar_valid,
  input  logic                  m_ar_ready,
  output logic [ADDR_WIDTH-1:0] m_ar_addr,
  output logic [ID_WIDTH:0]     m_ar_id,
  output logic [7:0]            m_ar_len,
  output logic [2:0]            m_ar_size,
  output logic [1:0]            m_ar_burst,
  input  logic                  m_r_valid,
  output logic                  m_r_ready,
  input  logic [DATA_WIDTH-1:0] m_r_data,
  input  logic [ID_WIDTH:0]     m_r_id,
  input  logic [1:0]            m_r_resp,
  input  logic                  m_r_last,
  output logic                  id_err
`ifdef AXI_RD_ARB_PERF_EN
  ,
  output logic [31:0]           perf_grant0,
  output logic [31:0]           perf_grant1,
  output logic [31:0]           perf_wait0,
  output logic [31:0]           perf_wait1
`endif
);

  // state | meaning
  // IDLE  | arbitrate; ar_ready offered to the winner only
  // ADDR  | registered AR presented downstream until m_ar_ready
  // DATA  | R beats routed to r_gnt until the last-beat handshake
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t                r_state;
  logic                  r_rr;
  logic                  r_gnt;
  logic                  r_m_ar_valid;
  logic                  r_id_err;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [ID_WIDTH:0]     r_ar_id;
  logic [7:0]            r_ar_len;
  logic [2:0]            r_ar_size;
  logic [1:0]            r_ar_burst;

  logic w_idle;
  logic w_data;
  logic w_sel;
  logic w_ar_hs;
  logic w_r_hs;

  // rst_n gates the grant so ar_ready reads 0 while reset is held
  assign w_idle  = (r_state == ST_IDLE) && rst_n;
  assign w_data  = (r_state == ST_DATA);
  assign w_sel   = (s0_ar_valid && s1_ar_valid) ? ~r_rr : s1_ar_valid;
  assign s0_ar_ready = w_idle && s0_ar_valid && !w_sel;
  assign s1_ar_ready = w_idle && s1_ar_valid && w_sel;
  assign w_ar_hs = s0_ar_ready || s1_ar_ready;

  assign m_r_ready  = w_data && (r_gnt ? s1_r_ready : s0_r_ready);
  assign w_r_hs     = m_r_valid && m_r_ready;
  assign s0_r_valid = w_data && !r_gnt && m_r_valid;
  assign s1_r_valid = w_data && r_gnt && m_r_valid;
  assign s0_r_data  = m_r_data;
  assign s1_r_data  = m_r_data;
  assign s0_r_id    = m_r_id[ID_WIDTH-1:0];
  assign s1_r_id    = m_r_id[ID_WIDTH-1:0];
  assign s0_r_resp  = m_r_resp;
  assign s1_r_resp  = m_r_resp;
  assign s0_r_last  = m_r_last;
  assign s1_r_last  = m_r_last;

  assign m_ar_valid = r_m_ar_valid;
  assign m_ar_addr  = r_ar_addr;
  assign m_ar_id    = r_ar_id;
  assign m_ar_len   = r_ar_len;
  assign m_ar_size  = r_ar_size;
  assign m_ar_burst = r_ar_burst;
  assign id_err     = r_id_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rr         <= 1'b1;
      r_gnt        <= 1'b0;
      r_m_ar_valid <= 1'b0;
      r_id_err     <= 1'b0;
      r_ar_addr    <= '0;
      r_ar_id      <= '0;
      r_ar_len     <= '0;
      r_ar_size    <= '0;
      r_ar_burst   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ar_hs) begin
            r_gnt        <= w_sel;
            r_rr         <= w_sel;
            r_m_ar_valid <= 1'b1;
            r_ar_addr    <= w_sel ? s1_ar_addr  : s0_ar_addr;
            r_ar_id      <= {w_sel, (w_sel ? s1_ar_id : s0_ar_id)};
            r_ar_len     <= w_sel ? s1_ar_len   : s0_ar_len;
            r_ar_size    <= w_sel ? s1_ar_size  : s0_ar_size;
            r_ar_burst   <= w_sel ? s1_ar_burst : s0_ar_burst;
            r_state      <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_ar_ready) begin
            r_m_ar_valid <= 1'b0;
            r_state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_r_hs) begin
            if (m_r_id[ID_WIDTH] != r_gnt) r_id_err <= 1'b1;
            if (m_r_last) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef AXI_RD_ARB_PERF_EN
  logic [31:0] r_perf_grant0;
  logic [31:0] r_perf_grant1;
  logic [31:0] r_perf_wait0;
  logic [31:0] r_perf_wait1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_grant0 <= '0;
      r_perf_grant1 <= '0;
      r_perf_wait0  <= '0;
      r_perf_wait1  <= '0;
    end else begin
      if (s0_ar_ready && r_perf_grant0 != 32'hFFFF_FFFF) r_perf_grant0 <= r_perf_grant0 + 32'd1;
      if (s1_ar_ready && r_perf_grant1 != 32'hFFFF_FFFF) r_perf_grant1 <= r_perf_grant1 + 32'd1;
      if (s0_ar_valid && !s0_ar_ready && r_perf_wait0 != 32'hFFFF_FFFF)
        r_perf_wait0 <= r_perf_wait0 + 32'd1;
      if (s1_ar_valid && !s1_ar_ready && r_perf_wait1 != 32'hFFFF_FFFF)
        r_perf_wait1 <= r_perf_wait1 + 32'd1;
    end
  end

  assign perf_grant0 = r_perf_grant0;
  assign perf_grant1 = r_perf_grant1;
  assign perf_wait0  = r_perf_wait0;
  assign perf_wait1  = r_perf_wait1;
`endif

endmodule
